// File: rtl/fft32_seq_ctrl_pkg.sv
// fft32_seq_ctrl_pkg: shared sequencer states, frame geometry and twiddle widths
package fft32_seq_ctrl_pkg;
  localparam int NBEAT_DEF  = 8;
  localparam int AW_DEF     = 3;
  localparam int BF_LAT_DEF = 3;
  localparam int LANES      = 4;
  localparam int TW_GRP_W   = 3;
  localparam int TW_STAGE_W = 1;
  typedef enum logic [2:0] {IDLE, LOAD, STG0, WAIT0, STG1, WAIT1, DRAIN} state_e;
endpackage

// File: rtl/fft32_seq_ctrl_dly.sv
// fft_seq_dly: fixed-depth valid+data shift register aligning butterfly write-back with its read
module fft_seq_dly #(
  parameter int DEPTH = 3,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  output logic [W-1:0] out_d
);
  logic [DEPTH-1:0] v_q, v_d;
  logic [W-1:0] d_q [DEPTH];
  logic [W-1:0] d_d [DEPTH];
  // shift one slot per cycle, new read enters slot 0
  always_comb begin
    v_d[0] = in_v;
    d_d[0] = in_d;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = d_q[i-1];
    end
  end
  // clearing on reset drops any in-flight write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign out_v = v_q[DEPTH-1];
  assign out_d = d_q[DEPTH-1];
endmodule

// File: rtl/fft32_seq_ctrl.sv
// fft32_seq_ctrl: frame sequencer for the 32-point FFT (optional FFT_SEQ_STATS_EN adds frame/stall counters)
module fft32_seq_ctrl
  import fft32_seq_ctrl_pkg::*;
#(
  parameter int NBEAT  = NBEAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                frm_valid,
  output logic                frm_ready,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [AW-1:0]       rd_addr,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [AW-1:0]       wr_addr,
  output logic                tw_start,
  output logic                tw_stage,
  output logic [TW_GRP_W-1:0] tw_grp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0]         frm_cnt,
  output logic [15:0]         stall_cnt
`endif
);
  state_e state_q, state_d;
  logic [AW-1:0] beat_q, beat_d;
  logic done_q, done_d;
  logic stg, last_beat, wait_end, hs, dly_v;
  logic [AW:0] dly_out;
  // stage reads (not drain reads) are the ones that produce a write-back
  fft_seq_dly #(.DEPTH(BF_LAT), .W(AW + 1)) u_dly (
    .clk  (CLK),
    .rst  (RST),
    .in_v (stg),
    .in_d ({rd_bank, rd_addr}),
    .out_v(dly_v),
    .out_d(dly_out)
  );
  // status decodes; the beat counter doubles as the wait-state timer
  always_comb begin
    stg       = state_q == STG0 || state_q == STG1;
    last_beat = beat_q == AW'(NBEAT - 1);
    wait_end  = beat_q == AW'(BF_LAT - 1);
    hs        = state_q == DRAIN && out_ready;
  end
  // next state, beat advance and end-of-frame pulse
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q + AW'(1);
    done_d  = 1'b0;
    case (state_q)
      IDLE:    state_d = frm_valid ? LOAD : IDLE;
      LOAD:    state_d = last_beat ? STG0 : LOAD;
      STG0:    state_d = last_beat ? WAIT0 : STG0;
      WAIT0:   state_d = wait_end ? STG1 : WAIT0;
      STG1:    state_d = last_beat ? WAIT1 : STG1;
      WAIT1:   state_d = wait_end ? DRAIN : WAIT1;
      DRAIN: begin
        beat_d  = hs ? beat_q + AW'(1) : beat_q;
        done_d  = hs && last_beat;
        state_d = done_d ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q || state_q == IDLE) beat_d = '0;
  end
  // state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end
  // buffer, twiddle and stream outputs; write bank is the opposite of the delayed read bank
  always_comb begin
    frm_ready = state_q == IDLE;
    busy      = !frm_ready;
    rd_en     = stg || state_q == DRAIN;
    rd_bank   = state_q == STG1;
    rd_addr   = rd_en ? beat_q : '0;
    tw_start  = stg && beat_q == '0;
    tw_stage  = state_q == STG1;
    tw_grp    = stg ? TW_GRP_W'(beat_q) : '0;
    out_valid = state_q == DRAIN;
    out_last  = out_valid && last_beat;
    wr_en     = state_q == LOAD || dly_v;
    wr_bank   = dly_v && !dly_out[AW];
    wr_addr   = state_q == LOAD ? beat_q : dly_v ? dly_out[AW-1:0] : '0;
    done      = done_q;
  end
`ifdef FFT_SEQ_STATS_EN
  logic [15:0] frm_cnt_q, frm_cnt_d, stall_cnt_q, stall_cnt_d;
  // frame count wraps, stall count saturates
  always_comb begin
    frm_cnt_d   = frm_cnt_q + 16'(done_d);
    stall_cnt_d = (state_q == DRAIN && !out_ready && stall_cnt_q != '1) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  // statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      frm_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      frm_cnt_q   <= frm_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign frm_cnt   = frm_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// tb_fft32_seq_ctrl: timeline-model check of fft32_seq_ctrl plus directed timing pins
module tb_fft32_seq_ctrl;
  localparam int BF = 3;
  localparam int W0 = 9 + BF;
  localparam int S1 = 17 + BF;
  localparam int W1 = S1 + BF;
  localparam int DR = S1 + 8 + BF;
  logic CLK = 1'b0, RST = 1'b1, frm_valid = 1'b0, out_ready = 1'b1;
  logic frm_ready, rd_en, rd_bank, wr_en, wr_bank, tw_start, tw_stage, out_valid, out_last, busy, done;
  logic [2:0] rd_addr, wr_addr, tw_grp;
  logic frm_ready1, rd_en1, rd_bank1, wr_en1, wr_bank1, tw_start1, tw_stage1, out_valid1, out_last1, busy1, done1;
  logic [2:0] rd_addr1, wr_addr1, tw_grp1;
`ifdef FFT_SEQ_STATS_EN
  logic [15:0] frm_cnt, stall_cnt, frm_cnt1, stall_cnt1;
`endif
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int cyc = 0, acc = 0, dk = 0, frm_m = 0, stall_m = 0, hs_cnt = 0;
  bit busy_m = 0, done_m = 0;

  fft32_seq_ctrl #(.NBEAT(8), .BF_LAT(BF), .AW(3)) dut (
    .CLK(CLK), .RST(RST), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .tw_start(tw_start), .tw_stage(tw_stage), .tw_grp(tw_grp),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef FFT_SEQ_STATS_EN
    , .frm_cnt(frm_cnt), .stall_cnt(stall_cnt)
`endif
  );
  fft32_seq_ctrl #(.NBEAT(8), .BF_LAT(1), .AW(3)) dut1 (
    .CLK(CLK), .RST(RST), .frm_valid(frm_valid), .frm_ready(frm_ready1),
    .rd_en(rd_en1), .rd_bank(rd_bank1), .rd_addr(rd_addr1),
    .wr_en(wr_en1), .wr_bank(wr_bank1), .wr_addr(wr_addr1),
    .tw_start(tw_start1), .tw_stage(tw_stage1), .tw_grp(tw_grp1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .busy(busy1), .done(done1)
`ifdef FFT_SEQ_STATS_EN
    , .frm_cnt(frm_cnt1), .stall_cnt(stall_cnt1)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected outputs from the frame timeline: offset since acceptance and drained beat count
  function automatic logic [19:0] model_out(input bit b, input int off, input int k, input bit dn);
    logic re, rb, we, wb, ts, tst, ov, ol;
    logic [2:0] ra, wa, tg;
    {re, rb, we, wb, ts, tst, ov, ol} = '0;
    {ra, wa, tg} = '0;
    if (b) begin
      if (off >= 1 && off <= 8) begin we = 1; wa = 3'(off - 1); end
      else if (off >= W0 && off < W0 + 8) begin we = 1; wb = 1; wa = 3'(off - W0); end
      else if (off >= W1 && off < W1 + 8) begin we = 1; wa = 3'(off - W1); end
      if (off >= 9 && off < 17) begin re = 1; ra = 3'(off - 9); tg = ra; ts = off == 9; end
      else if (off >= S1 && off < S1 + 8) begin re = 1; rb = 1; ra = 3'(off - S1); tg = ra; tst = 1; ts = off == S1; end
      else if (off >= DR) begin re = 1; ra = 3'(k); ov = 1; ol = k == 7; end
    end
    return {!b, b, dn && !b, re, rb, ra, we, wb, wa, ts, tst, tg, ov, ol};
  endfunction

  // compare this cycle against the model, then advance the model with the inputs the next edge samples
  always begin
    int off;
    @(negedge CLK);
    off = cyc - acc;
    if (chk_en) begin
      chk("outs", {frm_ready, busy, done, rd_en, rd_bank, rd_addr, wr_en, wr_bank, wr_addr,
                   tw_start, tw_stage, tw_grp, out_valid, out_last}, model_out(busy_m, off, dk, done_m));
`ifdef FFT_SEQ_STATS_EN
      chk("frm_cnt", frm_cnt, frm_m);
      chk("stall_cnt", stall_cnt, stall_m);
`endif
    end
    if (out_valid && out_ready) hs_cnt++;
    if (RST) begin
      busy_m = 0; done_m = 0; dk = 0; frm_m = 0; stall_m = 0;
    end else begin
      done_m = 0;
      if (!busy_m) begin
        if (frm_valid) begin busy_m = 1; acc = cyc; end
      end else if (off >= DR) begin
        if (out_ready) begin
          dk++;
          if (dk == 8) begin busy_m = 0; done_m = 1; dk = 0; frm_m = (frm_m + 1) % 65536; end
        end else if (stall_m < 65535) stall_m++;
      end
    end
    cyc++;
  end

  task automatic start_frame();
    @(posedge CLK); #1 frm_valid = 1;
    @(posedge CLK); #1 frm_valid = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 300) begin @(negedge CLK); n++; end
    chk(nm, done, 1);
  endtask

  initial begin
    int ts_n = 0, ov_first = -1, ov_last = -1, ol_at = -1, done_at = -1, ov1_first = -1, done1_at = -1;
    int ld_ok = 0, wb1_ok = 0, we_n = 0, dn_n = 0, n = 0;
    int ts_at[4] = '{default: -1};
    logic [15:0] s0, f0;
    s0 = 0; f0 = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 0; chk_en = 1;
    @(negedge CLK);
    chk("reset", {frm_ready, busy, done, wr_en, rd_en, out_valid, tw_start, rd_addr, wr_addr}, 13'b1000000000000);
    // single frame, full timing pinned to hand-computed cycle numbers
    start_frame();
    for (int c = 1; c <= 45; c++) begin
      @(negedge CLK);
      if (tw_start && ts_n < 4) begin ts_at[ts_n] = c; ts_n++; end
      if (out_valid) begin if (ov_first < 0) ov_first = c; ov_last = c; end
      if (out_last) ol_at = c;
      if (done) done_at = c;
      if (out_valid1 && ov1_first < 0) ov1_first = c;
      if (done1) done1_at = c;
      if (c <= 8 && wr_en && !wr_bank && wr_addr == 3'(c - 1)) ld_ok++;
      if (c >= 12 && c <= 19 && wr_en && wr_bank && wr_addr == 3'(c - 12)) wb1_ok++;
    end
    chk("tw_start_n", ts_n, 2);
    chk("tw_start_a", ts_at[0], 9);
    chk("tw_start_b", ts_at[1], 20);
    chk("load_wr", ld_ok, 8);
    chk("stg0_wb", wb1_ok, 8);
    chk("first_ov", ov_first, 31);
    chk("last_ov", ov_last, 38);
    chk("out_last", ol_at, 38);
    chk("done_at", done_at, 39);
    chk("bf1_first_ov", ov1_first, 27);
    chk("bf1_done_at", done1_at, 35);
    // drain backpressure 1,0,0,1
`ifdef FFT_SEQ_STATS_EN
    s0 = stall_cnt;
`endif
    hs_cnt = 0;
    start_frame();
    while (!out_valid && n < 100) begin @(negedge CLK); n++; end
    chk("bp_reach_drain", out_valid, 1);
    @(posedge CLK); #1 out_ready = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_hold_addr", rd_addr, 1);
    @(posedge CLK); #1 out_ready = 1;
    wait_done("bp_done");
    chk("bp_beats", hs_cnt, 8);
`ifdef FFT_SEQ_STATS_EN
    chk("bp_stall", stall_cnt - s0, 2);
`endif
    // reset in stage 1 aborts the frame
    repeat (5) @(posedge CLK);
    start_frame();
    repeat (21) @(posedge CLK);
    #1 RST = 1;
    @(negedge CLK);
    chk("stg1_at22", {rd_en, rd_bank, tw_stage}, 3'b111);
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK);
    chk("rst_idle", {frm_ready, busy}, 2'b10);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (wr_en) we_n++;
      if (done) dn_n++;
    end
    chk("rst_no_wr", we_n, 0);
    chk("rst_no_done", dn_n, 0);
    // frm_valid held: back-to-back frames
    @(posedge CLK); #1 frm_valid = 1;
`ifdef FFT_SEQ_STATS_EN
    f0 = frm_cnt;
`endif
    wait_done("b2b_done1");
    @(negedge CLK);
    chk("b2b_reload", {busy, wr_en, wr_bank, wr_addr}, 6'b110000);
`ifdef FFT_SEQ_STATS_EN
    chk("b2b_cnt1", frm_cnt - f0, 1);
`endif
    @(posedge CLK); #1 frm_valid = 0;
    wait_done("b2b_done2");
`ifdef FFT_SEQ_STATS_EN
    chk("b2b_cnt2", frm_cnt - f0, 2);
`endif
    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK);
      #1;
      frm_valid = $urandom_range(0, 3) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      RST = $urandom_range(0, 499) == 0;
    end
    @(posedge CLK); #1 RST = 0; frm_valid = 0; out_ready = 1;
    repeat (60) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
